// File: rtl/inputs_workload_merge_pkg.sv
// Shared definitions for the workload merge (fan-in) stage: descriptor field layout
// and merge-mode encoding, kept identical to the fan-out stage's config values.
package inputs_workload_merge_pkg;

    localparam int unsigned MergeReplicate = 0;
    localparam int unsigned MergeSplit     = 1;

    // Descriptor is {id, size} with size in the LSBs.
    localparam int unsigned WlSizeLsb = 0;

    function automatic int unsigned wl_id_lsb(input int unsigned size_width);
        return WlSizeLsb + size_width;
    endfunction

endpackage

// File: rtl/workload_size_reducer.sv
// Combinational saturating sum of num_in_p workload sizes; overflow_o flags that the
// true sum did not fit in size_width_p bits and sum_o was clamped to all-ones.
module workload_size_reducer #(
    parameter int unsigned num_in_p     = 4,
    parameter int unsigned size_width_p = 8
) (
    input  logic [num_in_p-1:0][size_width_p-1:0] size_i,
    output logic [size_width_p-1:0]               sum_o,
    output logic                                  overflow_o
);

    localparam int unsigned SumW = size_width_p + $clog2(num_in_p);

    logic [SumW-1:0] sum_full;

    always_comb begin
        sum_full = '0;
        for (int unsigned i = 0; i < num_in_p; i++) begin
            sum_full = sum_full + SumW'(size_i[i]);
        end
        overflow_o = sum_full > SumW'({size_width_p{1'b1}});
        sum_o      = overflow_o ? '1 : sum_full[size_width_p-1:0];
    end

endmodule

// File: rtl/inputs_workload_merge.sv
// Fan-in of per-chiplet workload pieces into one descriptor via one-entry input slots.
// Define INPUTS_WORKLOAD_MERGE_ID_CHECK_EN to flag id mismatches on error_o.
module inputs_workload_merge
    import inputs_workload_merge_pkg::*;
#(
    parameter int unsigned id_width_p      = 4,
    parameter int unsigned size_width_p    = 8,
    parameter int unsigned num_in_p        = 4,
    parameter int unsigned inputs_config_p = MergeSplit,
    parameter int unsigned width_p         = id_width_p + size_width_p
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_in_p-1:0]               v_i,
    input  logic [num_in_p-1:0][width_p-1:0]  data_i,
    output logic [num_in_p-1:0]               ready_o,
    output logic                              v_o,
    output logic [width_p-1:0]                data_o,
    input  logic                              ready_i,
    output logic                              overflow_o,
    output logic                              error_o
);

    localparam int unsigned IdLsb = wl_id_lsb(size_width_p);

    if (inputs_config_p != MergeReplicate && inputs_config_p != MergeSplit) begin : g_bad_config
        $error("inputs_workload_merge: unsupported inputs_config_p");
    end

    logic [num_in_p-1:0]                   slot_v_q, slot_v_d, take;
    logic [num_in_p-1:0][width_p-1:0]      slot_data_q;
    logic [num_in_p-1:0][size_width_p-1:0] slot_size;
    logic                                  all_v, out_free, merge;
    logic [size_width_p-1:0]               sum, merged_size;
    logic                                  sum_sat, sat_hit;
    logic [width_p-1:0]                    merged;
    logic                                  v_q, overflow_q;
    logic [width_p-1:0]                    data_q;

    always_comb begin
        for (int unsigned j = 0; j < num_in_p; j++) begin
            slot_size[j] = slot_data_q[j][WlSizeLsb +: size_width_p];
        end
    end

    workload_size_reducer #(
        .num_in_p    (num_in_p),
        .size_width_p(size_width_p)
    ) u_reducer (
        .size_i    (slot_size),
        .sum_o     (sum),
        .overflow_o(sum_sat)
    );

    always_comb begin
        all_v       = &slot_v_q;
        out_free    = ~v_q | ready_i;
        merge       = all_v & out_free;
        take        = v_i & ~slot_v_q;
        // A merge only fires with every slot full, so nothing can be taken on that edge.
        slot_v_d    = merge ? '0 : (slot_v_q | take);
        merged_size = (inputs_config_p == MergeSplit) ? sum : slot_size[0];
        sat_hit     = (inputs_config_p == MergeSplit) & sum_sat;
        merged      = {slot_data_q[0][IdLsb +: id_width_p], merged_size};
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            slot_v_q    <= '0;
            slot_data_q <= '0;
            v_q         <= 1'b0;
            data_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            slot_v_q <= slot_v_d;
            for (int unsigned j = 0; j < num_in_p; j++) begin
                if (take[j]) slot_data_q[j] <= data_i[j];
            end
            if (merge) begin
                v_q    <= 1'b1;
                data_q <= merged;
            end else if (v_q & ready_i) begin
                v_q <= 1'b0;
            end
            if (merge & sat_hit) overflow_q <= 1'b1;
        end
    end

`ifdef INPUTS_WORKLOAD_MERGE_ID_CHECK_EN
    logic id_mismatch, error_q;

    always_comb begin
        id_mismatch = 1'b0;
        for (int unsigned j = 1; j < num_in_p; j++) begin
            if (slot_data_q[j][IdLsb +: id_width_p] != slot_data_q[0][IdLsb +: id_width_p]) begin
                id_mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            error_q <= 1'b0;
        end else if (merge & id_mismatch) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    // Non-zero slot ids are only needed by the id check.
    logic unused_ids;

    always_comb begin
        unused_ids = 1'b0;
        for (int unsigned j = 0; j < num_in_p; j++) begin
            unused_ids = unused_ids ^ (^slot_data_q[j][IdLsb +: id_width_p]);
        end
    end

    assign error_o = 1'b0;
`endif

    assign ready_o    = ~slot_v_q;
    assign v_o        = v_q;
    assign data_o     = data_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_inputs_workload_merge.sv
// Bench for inputs_workload_merge: split (mode 1) and replicate (mode 0) instances driven
// in parallel, checked cycle by cycle against a transaction-level reference model.
module tb_inputs_workload_merge;

    localparam int unsigned IdW   = 4;
    localparam int unsigned SizeW = 8;
    localparam int unsigned NumIn = 4;
    localparam int unsigned W     = IdW + SizeW;
`ifdef INPUTS_WORKLOAD_MERGE_ID_CHECK_EN
    localparam bit IdCheck = 1'b1;
`else
    localparam bit IdCheck = 1'b0;
`endif

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b0;
    logic [NumIn-1:0]           v_i = '0;
    logic [NumIn-1:0][W-1:0]    data_i = '0;
    logic                       ready_i = 1'b1;

    logic [NumIn-1:0] ready_s, ready_r;
    logic             v_s, v_r, ovf_s, ovf_r, err_s, err_r;
    logic [W-1:0]     data_s, data_r;

    always #5 clk = ~clk;

    inputs_workload_merge #(
        .id_width_p(IdW), .size_width_p(SizeW), .num_in_p(NumIn), .inputs_config_p(1)
    ) dut_split (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i), .ready_o(ready_s),
        .v_o(v_s), .data_o(data_s), .ready_i(ready_i), .overflow_o(ovf_s), .error_o(err_s)
    );

    inputs_workload_merge #(
        .id_width_p(IdW), .size_width_p(SizeW), .num_in_p(NumIn), .inputs_config_p(0)
    ) dut_repl (
        .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i), .ready_o(ready_r),
        .v_o(v_r), .data_o(data_r), .ready_i(ready_i), .overflow_o(ovf_r), .error_o(err_r)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: pending piece per input, plus the descriptor currently offered.
    bit           m_full [NumIn];
    bit [W-1:0]   m_piece[NumIn];
    bit           m_v;
    bit [W-1:0]   m_out_s, m_out_r;
    bit           m_ovf_s, m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NumIn; j++) begin
            m_full[j]  = 1'b0;
            m_piece[j] = '0;
        end
        m_v = 1'b0; m_out_s = '0; m_out_r = '0; m_ovf_s = 1'b0; m_err = 1'b0;
    endtask

    // Effect of one rising edge given the inputs currently applied.
    task automatic model_edge();
        bit have_all = 1'b1;
        int total = 0;
        for (int j = 0; j < NumIn; j++) have_all &= m_full[j];
        if (have_all && (!m_v || ready_i)) begin
            for (int j = 0; j < NumIn; j++) total += int'(m_piece[j][SizeW-1:0]);
            m_out_s = {m_piece[0][W-1:SizeW], (total > 255) ? 8'hFF : 8'(total)};
            m_out_r = m_piece[0];
            if (total > 255) m_ovf_s = 1'b1;
            if (IdCheck) begin
                for (int j = 1; j < NumIn; j++) begin
                    if (m_piece[j][W-1:SizeW] != m_piece[0][W-1:SizeW]) m_err = 1'b1;
                end
            end
            m_v = 1'b1;
            for (int j = 0; j < NumIn; j++) m_full[j] = 1'b0;
        end else begin
            if (m_v && ready_i) m_v = 1'b0;
            for (int j = 0; j < NumIn; j++) begin
                if (v_i[j] && !m_full[j]) begin
                    m_full[j]  = 1'b1;
                    m_piece[j] = data_i[j];
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [NumIn-1:0] exp_ready;
        for (int j = 0; j < NumIn; j++) exp_ready[j] = ~m_full[j];
        check_eq("ready_s", 32'(ready_s), 32'(exp_ready));
        check_eq("ready_r", 32'(ready_r), 32'(exp_ready));
        check_eq("v_s", 32'(v_s), 32'(m_v));
        check_eq("v_r", 32'(v_r), 32'(m_v));
        check_eq("data_s", 32'(data_s), 32'(m_out_s));
        check_eq("data_r", 32'(data_r), 32'(m_out_r));
        check_eq("ovf_s", 32'(ovf_s), 32'(m_ovf_s));
        check_eq("ovf_r", 32'(ovf_r), 32'd0);
        check_eq("err_s", 32'(err_s), 32'(m_err));
        check_eq("err_r", 32'(err_r), 32'(m_err));
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_all(input logic [NumIn-1:0] v, input logic [IdW-1:0] id,
                           input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3);
        v_i       = v;
        data_i[0] = {id, s0};
        data_i[1] = {id, s1};
        data_i[2] = {id, s2};
        data_i[3] = {id, s3};
    endtask

    task automatic drain();
        v_i = '0;
        ready_i = 1'b1;
        cycle();
        cycle();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check_eq("rst_v_o", 32'(v_s), 32'd0);
        check_eq("rst_ready", 32'(ready_s), 32'hF);
        @(negedge clk);
        reset_n = 1'b1;

        // All inputs in one cycle, split sum 100.
        set_all(4'hF, 4'd3, 8'd10, 8'd20, 8'd30, 8'd40);
        cycle();
        check_eq("t1_ready_held", 32'(ready_s), 32'h0);
        check_eq("t1_v_early", 32'(v_s), 32'd0);
        v_i = '0;
        cycle();
        check_eq("t1_v", 32'(v_s), 32'd1);
        check_eq("t1_data_s", 32'(data_s), 32'h364);
        check_eq("t1_data_r", 32'(data_r), 32'h30A);
        drain();

        // Staggered arrival: input 2 arrives four cycles late.
        set_all(4'b1011, 4'd2, 8'd1, 8'd1, 8'd1, 8'd1);
        cycle();
        v_i = '0;
        repeat (3) begin
            cycle();
            check_eq("t2_ready", 32'(ready_s), 32'b0100);
        end
        v_i = 4'b0100;
        cycle();
        check_eq("t2_v_early", 32'(v_s), 32'd0);
        v_i = '0;
        cycle();
        check_eq("t2_v", 32'(v_s), 32'd1);
        check_eq("t2_data_s", 32'(data_s), 32'h204);
        drain();

        // Saturation stays sticky across a later normal merge.
        set_all(4'hF, 4'd3, 8'd200, 8'd100, 8'd0, 8'd0);
        cycle();
        v_i = '0;
        cycle();
        check_eq("t3_sat_data", 32'(data_s), 32'h3FF);
        check_eq("t3_ovf", 32'(ovf_s), 32'd1);
        check_eq("t3_repl_data", 32'(data_r), 32'h3C8);
        set_all(4'hF, 4'd3, 8'd10, 8'd20, 8'd30, 8'd40);
        cycle();
        v_i = '0;
        cycle();
        check_eq("t3_normal_data", 32'(data_s), 32'h364);
        check_eq("t3_ovf_sticky", 32'(ovf_s), 32'd1);
        drain();

        // Backpressure with a second full set waiting in the slots.
        ready_i = 1'b0;
        set_all(4'hF, 4'd3, 8'd10, 8'd20, 8'd30, 8'd40);
        cycle();
        v_i = '0;
        cycle();
        set_all(4'hF, 4'd5, 8'd1, 8'd2, 8'd3, 8'd4);
        cycle();
        v_i = '0;
        repeat (3) begin
            cycle();
            check_eq("t4_hold_data", 32'(data_s), 32'h364);
            check_eq("t4_hold_ready", 32'(ready_s), 32'h0);
        end
        ready_i = 1'b1;
        cycle();
        check_eq("t4_next_v", 32'(v_s), 32'd1);
        check_eq("t4_next_data", 32'(data_s), 32'h50A);
        check_eq("t4_next_repl", 32'(data_r), 32'h501);
        drain();

        // Id mismatch: replicate result keeps slot 0 id.
        set_all(4'hF, 4'd3, 8'd7, 8'd7, 8'd7, 8'd7);
        data_i[2] = {4'd5, 8'd7};
        cycle();
        v_i = '0;
        cycle();
        check_eq("t5_repl_data", 32'(data_r), 32'h307);
        check_eq("t5_err", 32'(err_r), 32'(IdCheck));
        drain();

        // Asynchronous reset with a partial set pending.
        set_all(4'b0011, 4'd1, 8'd9, 8'd9, 8'd9, 8'd9);
        cycle();
        v_i = '0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
        set_all(4'b1100, 4'd1, 8'd9, 8'd9, 8'd9, 8'd9);
        cycle();
        v_i = '0;
        repeat (3) begin
            cycle();
            check_eq("t6_no_v", 32'(v_s), 32'd0);
        end
        set_all(4'b0011, 4'd1, 8'd1, 8'd1, 8'd1, 8'd1);
        cycle();
        v_i = '0;
        cycle();
        check_eq("t6_fresh_v", 32'(v_s), 32'd1);
        drain();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [IdW-1:0] base_id;
            base_id = IdW'($urandom_range(0, 15));
            for (int j = 0; j < NumIn; j++) begin
                v_i[j] = ($urandom_range(0, 2) != 0);
                data_i[j][W-1:SizeW] = ($urandom_range(0, 15) == 0)
                                       ? IdW'($urandom_range(0, 15)) : base_id;
                data_i[j][SizeW-1:0] = ($urandom_range(0, 7) == 0)
                                       ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 60));
            end
            ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
